// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: default parameters, FSM state
// encoding and a counter-width helper.
package ps2_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_FILTER_LEN  = 4;
    localparam int DEF_TIMEOUT_CYC = 20000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Show-ahead FIFO for received frames. The head is visible on dout whenever
// the FIFO is non-empty and reads as 0 when empty. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module ps2_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W:0]     r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

    logic                w_pop_ok;
    logic                w_push_ok;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == (ADDR_W + 1)'(FIFO_DEPTH));
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

    // Pointer update; both pointers may move in the same cycle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array has no reset; stale entries are never visible because
    // dout is forced to 0 while empty, and a reset-free array maps to RAM.
    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises and deglitches the PS/2 lines,
// decodes 11-bit frames (start, LSB-first data, odd parity, stop), buffers
// good bytes in a show-ahead FIFO and flags errors with one-cycle pulses.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        rd,
    output logic                        rdy,
    output logic [DATA_W-1:0]           Q,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        par_err,
    output logic                        frm_err,
    output logic                        ovf_err,
    output logic                        to_err
);

    localparam int BIT_W = cnt_width(DATA_W - 1);
    localparam int FLT_W = cnt_width(FILTER_LEN - 1);
    localparam int TO_W  = cnt_width(TIMEOUT_CYC - 1);

    // Synchronisers and glitch filter.
    logic               r_clk_s1, r_clk_s2;
    logic               r_dat_s1, r_dat_s2;
    logic               r_fclk;
    logic [FLT_W-1:0]   r_flt_cnt;
    logic               w_flt_change;
    logic               w_sample;

    // Frame decoder state.
    rx_state_e          r_state,   w_state_nxt;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_nxt;
    logic [DATA_W-1:0]  r_shift,   w_shift_nxt;
    logic               r_par,     w_par_nxt;
    logic [TO_W-1:0]    r_to_cnt,  w_to_nxt;
    logic               w_push;
    logic               w_par_err;
    logic               w_frm_err;
    logic               w_to_err;

    // Error pulse registers and FIFO status.
    logic               r_par_err, r_frm_err, r_ovf_err, r_to_err;
    logic               w_full;
    logic               w_empty;
    logic               w_ovf;

    // Two-flop synchronisers; idle-high lines reset to 1.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign w_flt_change = (r_clk_s2 != r_fclk) && (r_flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign w_sample     = w_flt_change && r_fclk;

    // Glitch filter: count consecutive samples that disagree with r_fclk.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_fclk    <= 1'b1;
            r_flt_cnt <= '0;
        end else if (w_flt_change) begin
            r_fclk    <= r_clk_s2;
            r_flt_cnt <= '0;
        end else if (r_clk_s2 != r_fclk) begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end else begin
            r_flt_cnt <= '0;
        end
    end

    // Decoder state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_to_cnt  <= w_to_nxt;
        end
    end

    // Decoder next state, push request and error strobes.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_to_nxt    = r_to_cnt;
        w_push      = 1'b0;
        w_par_err   = 1'b0;
        w_frm_err   = 1'b0;
        w_to_err    = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_bit_nxt   = '0;
            w_to_nxt    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_to_nxt = '0;
                    if (w_sample && !r_dat_s2) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                        w_shift_nxt = '0;
                        w_par_nxt   = 1'b0;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        w_shift_nxt = {r_dat_s2, r_shift[DATA_W-1:1]};
                        w_par_nxt   = r_par ^ r_dat_s2;
                        if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                            w_state_nxt = PARITY;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        w_par_nxt   = r_par ^ r_dat_s2;
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        w_state_nxt = IDLE;
                        // r_par holds the XOR of data and parity bits: 1 means odd.
                        if (!r_par) begin
                            w_par_err = 1'b1;
                        end else if (!r_dat_s2) begin
                            w_frm_err = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            // Abandon a partial frame when ps2_clk stops falling for too long.
            if (r_state != IDLE) begin
                if (w_sample) begin
                    w_to_nxt = '0;
                end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_to_nxt    = '0;
                    w_state_nxt = IDLE;
                    w_bit_nxt   = '0;
                    w_to_err    = 1'b1;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
        end
    end

    // A good frame is lost only when the FIFO is full and nothing pops this cycle.
    assign w_ovf = w_push && w_full && !rd;

    // Register the error strobes into clean one-cycle output pulses.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf_err <= 1'b0;
            r_to_err  <= 1'b0;
        end else begin
            r_par_err <= w_par_err;
            r_frm_err <= w_frm_err;
            r_ovf_err <= w_ovf;
            r_to_err  <= w_to_err;
        end
    end

    ps2_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (w_push),
        .pop   (rd),
        .din   (r_shift),
        .dout  (Q),
        .full  (w_full),
        .empty (w_empty),
        .count (count)
    );

    assign rdy     = !w_empty;
    assign par_err = r_par_err;
    assign frm_err = r_frm_err;
    assign ovf_err = r_ovf_err;
    assign to_err  = r_to_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a table of single frames plus hand-written
// sequences for overflow, pop-on-push, timeout, glitch, enable and reset.
module tb_ps2_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int FLT   = 4;
    localparam int TO    = 20000;

    logic           CLK = 1'b0;
    logic           reset;
    logic           en;
    logic           ps2_clk;
    logic           ps2_data;
    logic           rd;
    logic           rdy;
    logic [DW-1:0]  Q;
    logic [2:0]     count;
    logic           par_err, frm_err, ovf_err, to_err;

    int total = 0;
    int bad   = 0;

    int n_par = 0, n_frm = 0, n_ovf = 0, n_to = 0, n_long = 0, n_multi = 0;
    logic prev_par = 1'b0, prev_frm = 1'b0, prev_ovf = 1'b0, prev_to = 1'b0;
    logic rdy_at5, rdy_at6;

    typedef struct {
        logic [7:0] d;
        logic       par_flip;
        logic       stop;
        logic [2:0] exp_count;
        logic [7:0] exp_q;
        int         exp_par;
        int         exp_frm;
    } vec_t;

    vec_t vecs[7];

    ps2_rx_fifo #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .FILTER_LEN  (FLT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .en       (en),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd       (rd),
        .rdy      (rdy),
        .Q        (Q),
        .count    (count),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .ovf_err  (ovf_err),
        .to_err   (to_err)
    );

    always #5 CLK = ~CLK;

    // Pulse monitor: counts each error pulse, flags pulses longer than one
    // cycle and cycles with more than one error asserted.
    always @(negedge CLK) begin
        if (par_err === 1'b1) n_par++;
        if (frm_err === 1'b1) n_frm++;
        if (ovf_err === 1'b1) n_ovf++;
        if (to_err  === 1'b1) n_to++;
        if ((par_err === 1'b1 && prev_par) || (frm_err === 1'b1 && prev_frm) ||
            (ovf_err === 1'b1 && prev_ovf) || (to_err  === 1'b1 && prev_to))
            n_long++;
        if ((int'(par_err === 1'b1) + int'(frm_err === 1'b1) +
             int'(ovf_err === 1'b1) + int'(to_err === 1'b1)) > 1)
            n_multi++;
        prev_par = (par_err === 1'b1);
        prev_frm = (frm_err === 1'b1);
        prev_ovf = (ovf_err === 1'b1);
        prev_to  = (to_err  === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One PS/2 bit: data set while clock high, then a 10-cycle low phase.
    // rdy is recorded 5 and 6 cycles after the falling edge, which brackets
    // the decoder's sample event; rd can be pulsed in exactly that cycle.
    task automatic send_bit(input logic b, input logic rd_pulse);
        ps2_data = b;
        wait_neg(5);
        ps2_clk = 1'b0;
        wait_neg(5);
        rdy_at5 = rdy;
        rd      = rd_pulse;
        wait_neg(1);
        rd      = 1'b0;
        rdy_at6 = rdy;
        wait_neg(4);
        ps2_clk = 1'b1;
        wait_neg(5);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop, input logic rd_stop);
        logic p;
        p = (~^d) ^ par_flip;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(p, 1'b0);
        send_bit(stop, rd_stop);
        ps2_data = 1'b1;
    endtask

    task automatic pop_one;
        rd = 1'b1;
        wait_neg(1);
        rd = 1'b0;
    endtask

    initial begin
        int p0, f0, o0, t0, e0, k, lat;

        //            data    pflip stop  count  Q      par frm
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 3'd1, 8'h1C, 0, 0};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 3'd0, 8'h00, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 3'd0, 8'h00, 0, 1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 3'd1, 8'h00, 0, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 3'd1, 8'hFF, 0, 0};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1, 0};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 3'd1, 8'h3C, 0, 0};

        reset = 1'b1; en = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
        wait_neg(3);
        reset = 1'b0;
        wait_neg(2);

        // Reset state.
        check("reset rdy",   32'(rdy),   0);
        check("reset Q",     32'(Q),     0);
        check("reset count", 32'(count), 0);
        check("reset errs",  32'({par_err, frm_err, ovf_err, to_err}), 0);

        // rd on an empty FIFO is ignored.
        e0 = n_par + n_frm + n_ovf + n_to;
        rd = 1'b1;
        wait_neg(3);
        rd = 1'b0;
        wait_neg(1);
        check("empty rd count", 32'(count), 0);
        check("empty rd rdy",   32'(rdy),   0);
        check("empty rd errs",  32'(n_par + n_frm + n_ovf + n_to - e0), 0);

        // Single-frame table.
        for (int i = 0; i < 7; i++) begin
            p0 = n_par;
            f0 = n_frm;
            send_frame(vecs[i].d, vecs[i].par_flip, vecs[i].stop, 1'b0);
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d Q", i),     32'(Q),     32'(vecs[i].exp_q));
            check($sformatf("vec%0d rdy latency", i), 32'({rdy_at5, rdy_at6}),
                  32'({1'b0, vecs[i].exp_count[0]}));
            check($sformatf("vec%0d par_err", i), 32'(n_par - p0), 32'(vecs[i].exp_par));
            check($sformatf("vec%0d frm_err", i), 32'(n_frm - f0), 32'(vecs[i].exp_frm));
            if (vecs[i].exp_count != 3'd0) pop_one();
        end
        check("table end count", 32'(count), 0);

        // Five frames into a four-deep FIFO: the fifth overflows.
        o0 = n_ovf;
        for (int j = 1; j <= 5; j++) send_frame(8'(j), 1'b0, 1'b1, 1'b0);
        check("ovf count", 32'(count), 4);
        check("ovf pulse", 32'(n_ovf - o0), 1);
        for (int j = 1; j <= 4; j++) begin
            check($sformatf("ovf pop %0d", j), 32'(Q), 32'(j));
            pop_one();
        end
        check("ovf drained rdy",   32'(rdy),   0);
        check("ovf drained Q",     32'(Q),     0);
        check("ovf drained count", 32'(count), 0);

        // Full FIFO with rd in the push cycle: both succeed, no overflow.
        for (int j = 0; j < 4; j++) send_frame(8'h11 + 8'(j), 1'b0, 1'b1, 1'b0);
        o0 = n_ovf;
        send_frame(8'h15, 1'b0, 1'b1, 1'b1);
        check("pop-push ovf",   32'(n_ovf - o0), 0);
        check("pop-push count", 32'(count), 4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("pop-push pop %0d", j), 32'(Q), 32'(8'h12 + 8'(j)));
            pop_one();
        end
        check("pop-push drained count", 32'(count), 0);

        // Start plus three data bits, then ps2_clk stays high.
        t0 = n_to;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        k = 0;
        while (to_err !== 1'b1 && k < TO + 100) begin
            wait_neg(1);
            k++;
        end
        // The last falling edge was driven 15 cycles before the wait loop.
        lat = 15 + k;
        wait_neg(1);
        check("timeout pulse", 32'(n_to - t0), 1);
        check("timeout latency window", 32'(lat >= TO + 3 && lat <= TO + 9), 1);
        check("timeout count", 32'(count), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("after timeout Q",     32'(Q),     32'h5A);
        check("after timeout count", 32'(count), 1);
        pop_one();

        // ps2_clk glitch one cycle shorter than the filter must be ignored.
        ps2_data = 1'b0;
        wait_neg(5);
        ps2_clk = 1'b0;
        wait_neg(FLT - 1);
        ps2_clk = 1'b1;
        wait_neg(20);
        ps2_data = 1'b1;
        p0 = n_par;
        f0 = n_frm;
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        check("glitch Q",       32'(Q),     32'h77);
        check("glitch count",   32'(count), 1);
        check("glitch errs",    32'((n_par - p0) + (n_frm - f0)), 0);
        pop_one();

        // Receive disabled: frame ignored, no error.
        e0 = n_par + n_frm + n_ovf + n_to;
        en = 1'b0;
        send_frame(8'h42, 1'b0, 1'b1, 1'b0);
        check("disabled count", 32'(count), 0);
        check("disabled errs",  32'(n_par + n_frm + n_ovf + n_to - e0), 0);
        en = 1'b1;
        wait_neg(5);

        // Reset mid-frame discards the partial frame.
        send_bit(1'b0, 1'b0);
        for (int j = 0; j < 4; j++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        wait_neg(2);
        check("mid reset count", 32'(count), 0);
        send_frame(8'h99, 1'b0, 1'b1, 1'b0);
        check("after reset Q",     32'(Q),     32'h99);
        check("after reset count", 32'(count), 1);
        pop_one();

        // Error pulses were single-cycle and never overlapped.
        check("pulse width", 32'(n_long),  0);
        check("pulse excl",  32'(n_multi), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
